axi_fifo_wr_data: RTL
=====================

Name: axi_fifo_wr_data

Overview:
- AXI4 slave write-side bridge: accepts AXI4 write bursts and emits each data beat as an AXI4-Stream beat toward the downstream FIFO/DAC path.
- It is the mirror of the read-side stream-to-AXI bridge, so a PS master can push sample data into the subsystem with ordinary burst writes.
- One burst is in flight at a time. The write response is issued after the final beat.
- Address values are not decoded; the whole address window maps to the stream.

Parameters:
- S_AXI_ID_WIDTH, 1, width of awid/bid.
- S_AXI_DATA_WIDTH, 32, AXI data width (multiple of 8).
- S_AXI_ADDR_WIDTH, 6, AXI address width.
- M_AXIS_DATA_WIDTH, 24, stream data width (≤ S_AXI_DATA_WIDTH).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- s_axi_awid  in  S_AXI_ID_WIDTH  burst ID.
- s_axi_awaddr  in  S_AXI_ADDR_WIDTH  address (ignored).
- s_axi_awlen  in  8  beats minus one.
- s_axi_awsize  in  3  beat size (ignored).
- s_axi_awburst  in  2  burst type.
- s_axi_awvalid  in  1  AW valid.
- s_axi_awready  out  1  AW ready.
- s_axi_wdata  in  S_AXI_DATA_WIDTH  write data.
- s_axi_wstrb  in  S_AXI_DATA_WIDTH/8  strobes (ignored; beat always forwarded).
- s_axi_wlast  in  1  master's last flag.
- s_axi_wvalid  in  1  W valid.
- s_axi_wready  out  1  W ready.
- s_axi_bid  out  S_AXI_ID_WIDTH  response ID.
- s_axi_bresp  out  2  response code.
- s_axi_bvalid  out  1  B valid.
- s_axi_bready  in  1  B ready.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  last beat of burst.
- m_axis_tdata  out  M_AXIS_DATA_WIDTH  stream data.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: state=IDLE; awready=0; bvalid=0; bresp=2'b00; bid=0; beat_cnt=0; err=0. Outputs decoded from state (wready, tvalid, tlast) are therefore 0 during reset.
- State machine (registered), IDLE -> DATA -> RESP -> IDLE.
- IDLE:
  - When awvalid=1 and awready=0, register awready=1 for exactly one cycle.
  - On the AW handshake: latch awid and awlen; beat_cnt=0; err=1 if awburst==2'b10 (WRAP) or 2'b11 (reserved), else err=0; go to DATA.
  - awready is never high outside IDLE, so there is no AW acceptance during DATA or RESP.
- DATA (zero-latency pass-through, no internal buffering):
  - m_axis_tvalid = s_axi_wvalid.
  - s_axi_wready = m_axis_tready.
  - m_axis_tdata = s_axi_wdata[M_AXIS_DATA_WIDTH-1:0]; upper bits are discarded.
  - m_axis_tlast = (beat_cnt==awlen_q), independent of wlast.
  - A beat transfers when wvalid & wready. On each transfer: beat_cnt+1, and err|=1 if wlast != (beat_cnt==awlen_q).
  - On the transfer with beat_cnt==awlen_q, go to RESP.
  - Early wlast does not shorten the burst: exactly awlen+1 beats are always consumed.
- RESP:
  - bvalid=1, bid=awid_q, bresp = err ? 2'b10 (SLVERR) : 2'b00 (OKAY).
  - wready=0 and tvalid=0 in this state.
  - On bvalid & bready: bvalid=0, go to IDLE. The next AW may be accepted starting the following cycle.
- Widths:
  - beat_cnt is 8 bits; awlen=255 gives 256 beats with no overflow issue, because the counter is compared before it increments.
- Stream stall: tready=0 holds wready=0; the AXI master must keep data stable per AXI rules, so no data is lost.
- Reset mid-burst: all state clears immediately; the partial stream burst is abandoned with no tlast, and no B response is issued.
- Simultaneous awvalid in RESP: ignored until IDLE.

Test Plan:
- Single beat: awlen=0, awid=1, wdata=0x00ABCDEF, wlast=1, tready=1 -> one stream beat tdata=0xABCDEF, tlast=1; bvalid with bid=1, bresp=00; 1 AW cycle then 1 W cycle.
- 4-beat INCR burst, wdata 0x11..0x44, tready toggled 1,0,1,0 -> exactly 4 stream beats in order, no duplicates or drops; wready mirrors tready; tlast only on 0x44; bresp=00.
- Protocol error: awlen=3 with wlast asserted on beat 2 -> 4 beats still forwarded, tlast on beat 4; bresp=10. Separately, awburst=WRAP with correct wlast -> bresp=10.
- B backpressure: bready held 0 for 5 cycles, with a new awvalid presented -> bvalid stays 1, awready stays 0, wready=0; after bready=1, IDLE, then awready pulses one cycle later.
- Max burst: awlen=255 with an incrementing pattern -> 256 beats, tlast on beat 256 only, bresp=00.
- Reset mid-burst: assert rst_n=0 asynchronously after beat 2 of 4 -> awready/bvalid/tvalid/wready drop without waiting for a clock edge; after release a fresh 1-beat burst completes normally with bresp=00.

Source files
------------

// File: rtl/axi_fifo_wr_data_if.sv
// AXI4 write-channel slave plus AXI4-Stream master bundle for axi_fifo_wr_data.
// 'slave' is the bridge side; 'master' is the PS/bench side that also owns tready.
interface axi_fifo_wr_data_if #(
  parameter int S_AXI_ID_WIDTH    = 1,
  parameter int S_AXI_DATA_WIDTH  = 32,
  parameter int S_AXI_ADDR_WIDTH  = 6,
  parameter int M_AXIS_DATA_WIDTH = 24
);
  logic [S_AXI_ID_WIDTH-1:0]     s_axi_awid;
  logic [S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr;
  logic [7:0]                    s_axi_awlen;
  logic [2:0]                    s_axi_awsize;
  logic [1:0]                    s_axi_awburst;
  logic                          s_axi_awvalid;
  logic                          s_axi_awready;
  logic [S_AXI_DATA_WIDTH-1:0]   s_axi_wdata;
  logic [S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb;
  logic                          s_axi_wlast;
  logic                          s_axi_wvalid;
  logic                          s_axi_wready;
  logic [S_AXI_ID_WIDTH-1:0]     s_axi_bid;
  logic [1:0]                    s_axi_bresp;
  logic                          s_axi_bvalid;
  logic                          s_axi_bready;
  logic                          m_axis_tvalid;
  logic                          m_axis_tready;
  logic                          m_axis_tlast;
  logic [M_AXIS_DATA_WIDTH-1:0]  m_axis_tdata;

  modport slave (
    input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    output s_axi_wready,
    output s_axi_bid, s_axi_bresp, s_axi_bvalid,
    input  s_axi_bready,
    output m_axis_tvalid, m_axis_tlast, m_axis_tdata,
    input  m_axis_tready
  );

  modport master (
    output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    input  s_axi_wready,
    input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
    output s_axi_bready,
    input  m_axis_tvalid, m_axis_tlast, m_axis_tdata,
    output m_axis_tready
  );
endinterface

// File: rtl/axi_fifo_wr_data.sv
// AXI4 write-burst to AXI4-Stream bridge: one burst in flight, W beats pass straight
// through to the stream, B response follows the final beat (SLVERR on WRAP/reserved or bad wlast).
module axi_fifo_wr_data #(
  parameter int S_AXI_ID_WIDTH    = 1,
  parameter int S_AXI_DATA_WIDTH  = 32,
  parameter int S_AXI_ADDR_WIDTH  = 6,
  parameter int M_AXIS_DATA_WIDTH = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  axi_fifo_wr_data_if.slave   bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, RESP = 2'd2} state_t;

  state_t                    state, state_nxt;
  logic                      awready_q, awready_nxt;
  logic                      bvalid_q, bvalid_nxt;
  logic [1:0]                bresp_q, bresp_nxt;
  logic [S_AXI_ID_WIDTH-1:0] bid_q, bid_nxt;
  logic [S_AXI_ID_WIDTH-1:0] awid_q, awid_nxt;
  logic [7:0]                awlen_q, awlen_nxt;
  logic [7:0]                beat_cnt, beat_cnt_nxt;
  logic                      err_q, err_nxt, err_upd;
  logic                      last_beat;
  logic                      wready, tvalid, tlast;
  logic                      unused;

  // Compared before increment, so awlen=255 never needs a 9th counter bit.
  assign last_beat = (beat_cnt == awlen_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      bid_q     <= '0;
      awid_q    <= '0;
      awlen_q   <= 8'd0;
      beat_cnt  <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      awready_q <= awready_nxt;
      bvalid_q  <= bvalid_nxt;
      bresp_q   <= bresp_nxt;
      bid_q     <= bid_nxt;
      awid_q    <= awid_nxt;
      awlen_q   <= awlen_nxt;
      beat_cnt  <= beat_cnt_nxt;
      err_q     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    awready_nxt  = 1'b0;
    bvalid_nxt   = bvalid_q;
    bresp_nxt    = bresp_q;
    bid_nxt      = bid_q;
    awid_nxt     = awid_q;
    awlen_nxt    = awlen_q;
    beat_cnt_nxt = beat_cnt;
    err_nxt      = err_q;
    err_upd      = err_q;
    wready       = 1'b0;
    tvalid       = 1'b0;
    tlast        = 1'b0;
    case (state)
      IDLE: begin
        awready_nxt = bus.s_axi_awvalid & ~awready_q;
        if (bus.s_axi_awvalid && awready_q) begin
          awid_nxt     = bus.s_axi_awid;
          awlen_nxt    = bus.s_axi_awlen;
          beat_cnt_nxt = 8'd0;
          err_nxt      = (bus.s_axi_awburst == 2'b10) || (bus.s_axi_awburst == 2'b11);
          state_nxt    = DATA;
        end
      end
      DATA: begin
        wready = bus.m_axis_tready;
        tvalid = bus.s_axi_wvalid;
        tlast  = last_beat;
        if (bus.s_axi_wvalid && bus.m_axis_tready) begin
          beat_cnt_nxt = beat_cnt + 8'd1;
          // wlast is only audited; the beat count from awlen decides where the burst ends.
          err_upd      = err_q | (bus.s_axi_wlast != last_beat);
          err_nxt      = err_upd;
          if (last_beat) begin
            state_nxt  = RESP;
            bvalid_nxt = 1'b1;
            bid_nxt    = awid_q;
            bresp_nxt  = err_upd ? 2'b10 : 2'b00;
          end
        end
      end
      RESP: begin
        if (bus.s_axi_bready) begin
          bvalid_nxt = 1'b0;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.s_axi_awready = awready_q;
  assign bus.s_axi_wready  = wready;
  assign bus.s_axi_bvalid  = bvalid_q;
  assign bus.s_axi_bresp   = bresp_q;
  assign bus.s_axi_bid     = bid_q;
  assign bus.m_axis_tvalid = tvalid;
  assign bus.m_axis_tlast  = tlast;
  assign bus.m_axis_tdata  = bus.s_axi_wdata[M_AXIS_DATA_WIDTH-1:0];

  // Address, size, strobes and the upper data bits carry no meaning for the stream.
  assign unused = ^{bus.s_axi_awaddr, bus.s_axi_awsize, bus.s_axi_wstrb, bus.s_axi_wdata};
endmodule
